// File: rtl/multiword_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
// State encoding, default width and slice width live here.
package multiword_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int NIB_W         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_slice4.sv
// 4-bit ripple-carry adder slice built from full-adder cells.
// Shared by every nibble of a multi-cycle operation.
module adder_slice4
    import multiword_add_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/multiword_add_ctrl.sv
// Multi-cycle add/subtract controller: one 4-bit slice swept over
// WIDTH/4 nibbles, LSB first, with a registered carry between cycles.
module multiword_add_ctrl
    import multiword_add_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NIBBLES = WIDTH / NIB_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [NIB_W-1:0]  a_nib;
    logic [NIB_W-1:0]  b_nib;
    logic [NIB_W-1:0]  s_nib;
    logic              c_nib;
    logic              last;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) begin
                a_nib = a_q[n*NIB_W +: NIB_W];
                b_nib = b_q[n*NIB_W +: NIB_W];
            end
        end
    end

    assign last = (idx == IDX_W'(NIBBLES - 1));

    adder_slice4 u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (s_nib),
        .cout (c_nib)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= sub ? ~b : b;
                        carry_q  <= sub;
                        idx      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (idx == IDX_W'(n))
                            sum[n*NIB_W +: NIB_W] <= s_nib;
                    end
                    carry_q <= c_nib;
                    if (last) begin
                        carry_out <= c_nib;
                        // Sign check on the top nibble, taken as it is produced
                        overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                     (s_nib[NIB_W-1] != a_q[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
